alu_iterative: RTL and testbench

//   Execute-stage ALU that consumes the 3-bit ALU control code and the two operands.
//   AND, XOR, SLL, ADD, SUB, ADDI and SRAI complete in one cycle.
//   MUL runs on an iterative radix-2 shift-add multiplier and stalls issue until it finishes.
//   A valid/ready handshake lets the pipeline control hold the instruction while the ALU is busy.

---
 rtl/alu_iterative.sv | 107 ++++++++++
 tb/tb_alu_iterative.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an
// iterative radix-2 shift-add multiplier behind a valid/ready handshake.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  logic [0:0]       state;
  logic [SW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] res;
  logic [SW-1:0]    shamt;

  assign ready_o  = (state == IDLE);
  assign shamt    = data2_i[SW-1:0];
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    res = '0;
    unique case (ALUCtrl_i)
      OP_AND:  res = data1_i & data2_i;
      OP_XOR:  res = data1_i ^ data2_i;
      OP_SLL:  res = data1_i << shamt;
      OP_ADD:  res = data1_i + data2_i;
      OP_SUB:  res = data1_i - data2_i;
      OP_MUL:  res = '0;
      OP_ADDI: res = data1_i + data2_i;
      OP_SRAI: res = $unsigned($signed(data1_i) >>> shamt);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      data_o  <= '0;
      zero_o  <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              mcand  <= data1_i;
              mplier <= data2_i;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              data_o  <= res;
              zero_o  <= (res == '0);
              valid_o <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Fixed WIDTH iterations; no early exit on a zero multiplier
          if (cnt == LAST) begin
            data_o  <= acc_next;
            zero_o  <= (acc_next == '0);
            valid_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: expected results queued at accept,
// popped by a monitor on every valid_o pulse.
module tb_alu_iterative;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  ALUCtrl_i = 3'b000;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        zero_o;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned n_pulses = 0;
  logic [31:0] sb_q[$];

  alu_iterative #(.WIDTH(32)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .valid_i(valid_i),
    .ALUCtrl_i(ALUCtrl_i),
    .data1_i(data1_i),
    .data2_i(data2_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o(data_o),
    .zero_o(zero_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ext;
    logic [63:0] prod;
    int sh;
    sh = int'(b[4:0]);
    ext = {{32{a[31]}}, a} >> sh;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      3'b000: return a & b;
      3'b001: return a ^ b;
      3'b010: return a << sh;
      3'b011: return a + b;
      3'b100: return a - b;
      3'b101: return prod[31:0];
      3'b110: return a + b;
      default: return ext[31:0];
    endcase
  endfunction

  always begin
    @(posedge clk_i);
    #1;
    if (valid_o) begin
      logic [31:0] e;
      n_pulses++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_valid: data_o=%h, required no pulse", data_o);
      end else begin
        e = sb_q.pop_front();
        if (data_o !== e || zero_o !== (e == 32'd0)) begin
          n_fails++;
          $display("FAIL result: data_o=%h zero_o=%b, required %h/%b",
                   data_o, zero_o, e, (e == 32'd0));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    if (ready_o) sb_q.push_back(model(op, a, b));
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100 && sb_q.size() != 0; i++) begin
      @(posedge clk_i);
      #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain_timeout: %0d pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    n_checks++;
    if ({ready_o, valid_o, data_o, zero_o} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
      n_fails++;
      $display("FAIL reset_state: r=%b v=%b d=%h z=%b, required 1/0/0/1",
               ready_o, valid_o, data_o, zero_o);
    end
  endtask

  task automatic test_arith();
    issue(3'b011, 32'd5, 32'd7);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 32'd12 || zero_o !== 1'b0) begin
      n_fails++;
      $display("FAIL add_latency: v=%b d=%h z=%b, required 1/0000000c/0",
               valid_o, data_o, zero_o);
    end
    issue(3'b100, 32'd3, 32'd3);
    n_checks++;
    if (zero_o !== 1'b1) begin
      n_fails++;
      $display("FAIL sub_zero: zero_o=%b, required 1", zero_o);
    end
    issue(3'b100, 32'd0, 32'd1);
    drain();
  endtask

  task automatic test_shifts();
    issue(3'b010, 32'd1, 32'd31);
    issue(3'b010, 32'd1, 32'h21);
    n_checks++;
    if (data_o !== 32'h2) begin
      n_fails++;
      $display("FAIL sll_mask: data_o=%h, required 00000002", data_o);
    end
    issue(3'b111, 32'h8000_0000, 32'd4);
    n_checks++;
    if (data_o !== 32'hF800_0000) begin
      n_fails++;
      $display("FAIL srai: data_o=%h, required f8000000", data_o);
    end
    drain();
  endtask

  task automatic test_mul_busy();
    int low;
    int p0;
    low = 0;
    p0 = int'(n_pulses);
    issue(3'b101, 32'h0000_FFFF, 32'h0001_0001);
    valid_i   = 1'b1;
    ALUCtrl_i = 3'b011;
    data1_i   = 32'd1;
    data2_i   = 32'd2;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) break;
      low++;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    n_checks++;
    if (low != 32) begin
      n_fails++;
      $display("FAIL mul_busy_cycles: %0d, required 32", low);
    end
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 32'hFFFF_FFFF) begin
      n_fails++;
      $display("FAIL mul_done: v=%b d=%h, required 1/ffffffff",
               valid_o, data_o);
    end
    drain();
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (int'(n_pulses) - p0 != 1) begin
      n_fails++;
      $display("FAIL mul_pulses: %0d, required 1", int'(n_pulses) - p0);
    end
  endtask

  task automatic test_mul_then_add();
    int i;
    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (i = 0; i < 40 && !ready_o; i++) begin
      @(posedge clk_i);
      #1;
    end
    n_checks++;
    if (!ready_o) begin
      n_fails++;
      $display("FAIL mul_ready_timeout: ready_o=%b, required 1", ready_o);
    end
    issue(3'b011, 32'd10, 32'd20);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 32'd30) begin
      n_fails++;
      $display("FAIL add_after_mul: v=%b d=%h, required 1/0000001e",
               valid_o, data_o);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    int p0;
    issue(3'b101, 32'd3, 32'd5);
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    sb_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || data_o !== 32'd0) begin
      n_fails++;
      $display("FAIL mid_mul_reset: r=%b v=%b d=%h, required 1/0/0",
               ready_o, valid_o, data_o);
    end
    p0 = int'(n_pulses);
    repeat (40) @(posedge clk_i);
    #1;
    n_checks++;
    if (int'(n_pulses) != p0 || ready_o !== 1'b1) begin
      n_fails++;
      $display("FAIL aborted_mul: pulses=%0d r=%b, required 0/1",
               int'(n_pulses) - p0, ready_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [4];
    ops[0] = 3'b000;
    ops[1] = 3'b001;
    ops[2] = 3'b110;
    ops[3] = 3'b111;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], $urandom, $urandom);
      n_checks++;
      if (valid_o !== 1'b1) begin
        n_fails++;
        $display("FAIL b2b_pulse%0d: valid_o=%b, required 1", i, valid_o);
      end
    end
    @(posedge clk_i);
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_idle: valid_o=%b, required 0", valid_o);
    end
    drain();
  endtask

  initial begin
    #1;
    test_reset();
    test_arith();
    test_shifts();
    test_mul_busy();
    test_mul_then_add();
    test_reset_mid_mul();
    test_back_to_back();
    repeat (2) @(posedge clk_i);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
